// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the word-serial RSA add/sub controller.
// No logic; latency and backpressure are defined by the modules that import it.
package rsa_pkg;
  localparam int RSA_WORDS = 32;
  localparam int RSA_WIDX  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } rsaState_t;
endpackage

// File: rtl/rsa_rr_arbiter.sv
// Round-robin winner select: combinational one-hot winner, priority starts after last grant.
// Zero latency; pointer advances only on iUpd, so a held request is never starved.
module rsa_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic            iClk,
  input  logic            iRstn,
  input  logic [NREQ-1:0] iReq,
  input  logic            iUpd,
  input  logic [PW-1:0]   iUpdIdx,
  output logic [NREQ-1:0] oWin,
  output logic [PW-1:0]   oWinIdx,
  output logic            oAny
);
  logic [PW-1:0] lastPtr;
  logic [PW-1:0] idx;

  // Reset pointer to the top index so requester 0 wins the first tie.
  always_ff @(posedge iClk) begin
    if (!iRstn)
      lastPtr <= PW'(NREQ - 1);
    else if (iUpd)
      lastPtr <= iUpdIdx;
  end

  always_comb begin
    oWin    = '0;
    oWinIdx = '0;
    oAny    = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PW'((int'(lastPtr) + i) % NREQ);
      if (!oAny && iReq[idx]) begin
        oAny      = 1'b1;
        oWin[idx] = 1'b1;
        oWinIdx   = idx;
      end
    end
  end
endmodule

// File: rtl/rsa_addsub_ctrl.sv
// Grants the shared 32-word add/sub datapath round-robin and sequences its word addresses.
// Grant to done is 34 cycles; requests wait (level) until granted, back-to-back period 35 cycles.
module rsa_addsub_ctrl
  import rsa_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                iClk,
  input  logic                iRstn,
  input  logic [NREQ-1:0]     iReq,
  input  logic [NREQ-1:0]     iAddSub,
  output logic [NREQ-1:0]     oGnt,
  output logic [NREQ-1:0]     oDone,
  output logic                oCarry,
  output logic                oStart,
  output logic                oAddSub,
  input  logic                iDataShift,
  input  logic                iOverflow,
  input  logic                iDone,
  output logic                oRdEn,
  output logic [RSA_WIDX-1:0] oRdAddr,
  output logic                oWrEn,
  output logic [RSA_WIDX-1:0] oWrAddr,
  output logic                oErr
);
  localparam int PW = $clog2(NREQ);
  localparam logic [RSA_WIDX-1:0] LAST_K = RSA_WIDX'(RSA_WORDS - 1);

  rsaState_t           state;
  logic [PW-1:0]       owner;
  logic [RSA_WIDX-1:0] k;
  logic [RSA_WIDX-1:0] kNext;
  logic [NREQ-1:0]     winOH;
  logic [PW-1:0]       winIdx;
  logic                anyReq;

  assign kNext = k + 1'b1;

  rsa_rr_arbiter #(.NREQ(NREQ), .PW(PW)) uArb (
    .iClk    (iClk),
    .iRstn   (iRstn),
    .iReq    (iReq),
    .iUpd    (state == ST_FIN),
    .iUpdIdx (owner),
    .oWin    (winOH),
    .oWinIdx (winIdx),
    .oAny    (anyReq)
  );

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state   <= ST_IDLE;
      owner   <= '0;
      k       <= '0;
      oGnt    <= '0;
      oDone   <= '0;
      oCarry  <= 1'b0;
      oStart  <= 1'b0;
      oAddSub <= 1'b0;
      oRdEn   <= 1'b0;
      oRdAddr <= '0;
      oWrEn   <= 1'b0;
      oWrAddr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (anyReq) begin
          state   <= ST_LOAD;
          owner   <= winIdx;
          oGnt    <= winOH;
          oAddSub <= iAddSub[winIdx];
          oRdEn   <= 1'b1;
          oRdAddr <= '0;
        end
        ST_LOAD: begin
          state   <= ST_RUN;
          k       <= '0;
          oStart  <= 1'b1;
          oWrEn   <= 1'b1;
          oWrAddr <= '0;
          oRdEn   <= 1'b1;
          oRdAddr <= RSA_WIDX'(1);
        end
        ST_RUN: begin
          oStart <= 1'b0;
          if (k == LAST_K) begin
            state   <= ST_FIN;
            oWrEn   <= 1'b0;
            oWrAddr <= '0;
            oRdEn   <= 1'b0;
            oRdAddr <= '0;
            oCarry  <= iOverflow;
            oDone   <= oGnt;
          end else begin
            // Read runs one word ahead of write to cover the 1-cycle memory latency.
            k       <= kNext;
            oWrAddr <= kNext;
            oRdEn   <= (kNext != LAST_K);
            oRdAddr <= (kNext != LAST_K) ? kNext + 1'b1 : '0;
          end
        end
        ST_FIN: begin
          state   <= ST_IDLE;
          oDone   <= '0;
          oCarry  <= 1'b0;
          oGnt    <= '0;
          oAddSub <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky protocol monitor; never alters sequencing.
  always_ff @(posedge iClk) begin
    if (!iRstn)
      oErr <= 1'b0;
    else if ((state == ST_RUN && (!iDataShift || (iDone != (k == LAST_K)))) ||
             (state != ST_RUN && iDone))
      oErr <= 1'b1;
  end
endmodule

// File: tb/tb_rsa_addsub_ctrl.sv
// Directed bench: word-serial datapath model plus cycle-exact checks of every controller output.
module tb_rsa_addsub_ctrl;
  localparam int NREQ = 2;

  logic            iClk = 1'b0;
  logic            iRstn = 1'b0;
  logic [NREQ-1:0] iReq = '0;
  logic [NREQ-1:0] iAddSub = '0;
  logic [NREQ-1:0] oGnt, oDone;
  logic            oCarry, oStart, oAddSub, oRdEn, oWrEn, oErr;
  logic            iDataShift, iOverflow, iDone;
  logic [4:0]      oRdAddr, oWrAddr;

  int checks = 0;
  int failures = 0;

  logic        injEn = 1'b0;
  int          injK = 0;
  logic [31:0] memA [32];
  logic [31:0] memB [32];
  logic [31:0] memR [32];
  logic        cinQ = 1'b0;
  logic        cin;
  logic [32:0] sum;

  always #5 iClk = ~iClk;

  // Datapath model: word add, or A + ~B with carry-in forced to mode on the first word.
  always_comb begin
    cin = oStart ? oAddSub : cinQ;
    sum = {1'b0, memA[oWrAddr]} + {1'b0, (oAddSub ? ~memB[oWrAddr] : memB[oWrAddr])} + {32'd0, cin};
  end
  assign iOverflow  = sum[32];
  assign iDataShift = oWrEn;
  assign iDone      = oWrEn && (oWrAddr == 5'd31 || (injEn && int'(oWrAddr) == injK));

  always @(posedge iClk) begin
    if (oWrEn) begin
      memR[oWrAddr] <= sum[31:0];
      cinQ          <= sum[32];
    end
  end

  rsa_addsub_ctrl #(.NREQ(NREQ)) dut (
    .iClk       (iClk),
    .iRstn      (iRstn),
    .iReq       (iReq),
    .iAddSub    (iAddSub),
    .oGnt       (oGnt),
    .oDone      (oDone),
    .oCarry     (oCarry),
    .oStart     (oStart),
    .oAddSub    (oAddSub),
    .iDataShift (iDataShift),
    .iOverflow  (iOverflow),
    .iDone      (iDone),
    .oRdEn      (oRdEn),
    .oRdAddr    (oRdAddr),
    .oWrEn      (oWrEn),
    .oWrAddr    (oWrAddr),
    .oErr       (oErr)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  addSub;
    logic [31:0] a0, aHi, b0, bHi;
    logic [1:0]  gnt;
    logic        mode;
    logic        carry;
    logic        zero;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic loadMem(input logic [31:0] a0, input logic [31:0] aHi,
                         input logic [31:0] b0, input logic [31:0] bHi);
    for (int i = 0; i < 32; i++) begin
      memA[i] = (i == 0) ? a0 : aHi;
      memB[i] = (i == 0) ? b0 : bHi;
    end
  endtask

  // Entered at the falling edge of the IDLE cycle t with iReq applied; returns at t+35 (IDLE again).
  task automatic runOp(input string tag, input logic [1:0] gnt, input logic mode,
                       input logic carry, input logic holdReq, input int pulseAt);
    logic [1:0] eG, eD;
    logic       eS, eW, eR, eA, eC;
    for (int c = 1; c <= 35; c++) begin
      @(negedge iClk);
      eG = (c <= 34) ? gnt : 2'b00;
      eD = (c == 34) ? gnt : 2'b00;
      eS = (c == 2);
      eW = (c >= 2 && c <= 33);
      eR = (c <= 32);
      eA = (c <= 34) ? mode : 1'b0;
      eC = (c == 34) ? carry : 1'b0;
      chk($sformatf("%s c%0d ctl{gnt,done,start,wr,rd,op,cy}", tag, c),
          {23'd0, oGnt, oDone, oStart, oWrEn, oRdEn, oAddSub, oCarry},
          {23'd0, eG, eD, eS, eW, eR, eA, eC});
      if (eW) chk($sformatf("%s c%0d wraddr", tag, c), oWrAddr, c - 2);
      if (eR) chk($sformatf("%s c%0d rdaddr", tag, c), oRdAddr, (c == 1) ? 0 : c - 1);
      if (c == 1 && !holdReq) iReq = iReq & ~gnt;
      if (pulseAt != 0 && c == pulseAt) begin
        iReq[1]    = 1'b1;
        iAddSub[0] = ~iAddSub[0];
      end
      if (pulseAt != 0 && c == pulseAt + 1) iReq[1] = 1'b0;
    end
  endtask

  initial begin
    logic bad;
    logic [31:0] orR;

    vecs[0] = '{req:2'b01, addSub:2'b00, a0:32'hFFFFFFFF, aHi:32'hFFFFFFFF, b0:32'd1, bHi:32'd0,
                gnt:2'b01, mode:1'b0, carry:1'b1, zero:1'b1};
    vecs[1] = '{req:2'b01, addSub:2'b01, a0:32'd5, aHi:32'd0, b0:32'd5, bHi:32'd0,
                gnt:2'b01, mode:1'b1, carry:1'b1, zero:1'b1};
    vecs[2] = '{req:2'b01, addSub:2'b01, a0:32'd0, aHi:32'd0, b0:32'd1, bHi:32'd0,
                gnt:2'b01, mode:1'b1, carry:1'b0, zero:1'b0};
    vecs[3] = '{req:2'b10, addSub:2'b10, a0:32'd0, aHi:32'd0, b0:32'd1, bHi:32'd0,
                gnt:2'b10, mode:1'b1, carry:1'b0, zero:1'b0};
    vecs[4] = '{req:2'b10, addSub:2'b01, a0:32'hFFFFFFFF, aHi:32'hFFFFFFFF, b0:32'd1, bHi:32'd0,
                gnt:2'b10, mode:1'b0, carry:1'b1, zero:1'b1};
    vecs[5] = '{req:2'b11, addSub:2'b00, a0:32'd0, aHi:32'd0, b0:32'd1, bHi:32'd0,
                gnt:2'b01, mode:1'b0, carry:1'b0, zero:1'b0};

    repeat (3) @(negedge iClk);
    chk("reset outputs", {12'd0, oGnt, oDone, oStart, oWrEn, oRdEn, oAddSub, oCarry, oErr, oRdAddr, oWrAddr}, 32'd0);

    // Both requesters held from reset: grants alternate 0,1,0,1 at 35-cycle spacing.
    iReq = 2'b11;
    iAddSub = 2'b10;
    loadMem(32'd5, 32'd0, 32'd5, 32'd0);
    iRstn = 1'b1;
    runOp("rr0", 2'b01, 1'b0, 1'b0, 1'b1, 0);
    runOp("rr1", 2'b10, 1'b1, 1'b1, 1'b1, 0);
    runOp("rr2", 2'b01, 1'b0, 1'b0, 1'b1, 0);
    runOp("rr3", 2'b10, 1'b1, 1'b1, 1'b1, 0);
    iReq = 2'b00;

    for (int v = 0; v < 6; v++) begin
      loadMem(vecs[v].a0, vecs[v].aHi, vecs[v].b0, vecs[v].bHi);
      iAddSub = vecs[v].addSub;
      iReq = vecs[v].req;
      runOp($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].mode, vecs[v].carry, 1'b0, 0);
      if (vecs[v].zero) begin
        orR = '0;
        for (int i = 0; i < 32; i++) orR = orR | memR[i];
        chk($sformatf("vec%0d result zero", v), orR, 32'd0);
      end
    end
    // Requester 1 was left pending by the tie in vec5 and must be served next.
    iAddSub = 2'b10;
    loadMem(32'd5, 32'd0, 32'd5, 32'd0);
    runOp("tie leftover", 2'b10, 1'b1, 1'b1, 1'b0, 0);
    chk("err clean", oErr, 1'b0);

    // Reset while running word 10.
    iReq = 2'b01;
    iAddSub = 2'b00;
    loadMem(32'd0, 32'd0, 32'd1, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge iClk);
      if (c == 1) iReq = 2'b00;
    end
    chk("mid reset k10 wraddr", oWrAddr, 32'd10);
    iRstn = 1'b0;
    @(negedge iClk);
    chk("mid reset outputs", {12'd0, oGnt, oDone, oStart, oWrEn, oRdEn, oAddSub, oCarry, oErr, oRdAddr, oWrAddr}, 32'd0);
    iRstn = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge iClk);
      if (oDone != 2'b00 || oGnt != 2'b00) bad = 1'b1;
    end
    chk("mid reset no done", bad, 1'b0);
    iReq = 2'b01;
    runOp("after reset", 2'b01, 1'b0, 1'b0, 1'b0, 0);

    // Late pulse on requester 1 and op toggle on requester 0 while 0 owns the datapath.
    iReq = 2'b01;
    iAddSub = 2'b00;
    loadMem(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0);
    runOp("pulse", 2'b01, 1'b0, 1'b1, 1'b0, 10);
    iAddSub = 2'b00;
    bad = 1'b0;
    repeat (40) begin
      @(negedge iClk);
      if (oGnt != 2'b00) bad = 1'b1;
    end
    chk("dropped req never granted", bad, 1'b0);

    // Early iDone at word 20 flags an error but the sequence still completes.
    chk("err before inject", oErr, 1'b0);
    injK = 20;
    injEn = 1'b1;
    iReq = 2'b01;
    iAddSub = 2'b01;
    loadMem(32'd5, 32'd0, 32'd5, 32'd0);
    runOp("inject", 2'b01, 1'b1, 1'b1, 1'b0, 0);
    injEn = 1'b0;
    chk("err set", oErr, 1'b1);
    iReq = 2'b10;
    iAddSub = 2'b00;
    loadMem(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0);
    runOp("post err", 2'b10, 1'b0, 1'b1, 1'b0, 0);
    chk("err sticky", oErr, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
